// File: rtl/order_book_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : order_book_pkg
//  Description : Shared types and default widths for the order book
//                read-modify-write controller.
//                  op_t    - order event opcode (ADD / CANCEL / QUERY / RSVD)
//                  err_t   - update report status code
//                  state_t - controller state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package order_book_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_CANCEL = 2'd1,
        OP_QUERY  = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_ILLEGAL   = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WR    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/order_book_update_ctrl_qty_alu.sv
`default_nettype none
// ============================================================================
//  Module      : qty_alu
//  Description : Combinational quantity arithmetic for one price level.
//                ADD    : rd + qty, saturated at all-ones.
//                CANCEL : rd - qty, clamped to zero with underflow flagged.
//  Ports       : op        - latched opcode (only CANCEL selects subtract)
//                rd        - quantity read from the level
//                qty       - order quantity
//                result    - value to write back
//                underflow - CANCEL quantity exceeded the level quantity
//  Revision    : 1.0 - initial release
// ============================================================================
module qty_alu
    import order_book_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] rd,
    input  logic [DATA_W-1:0] qty,
    output logic [DATA_W-1:0] result,
    output logic              underflow
);

    // One extra bit catches the carry used for saturation.
    logic [DATA_W:0] sum;

    always_comb begin
        sum       = {1'b0, rd} + {1'b0, qty};
        result    = '0;
        underflow = 1'b0;
        if (op == OP_CANCEL) begin
            if (qty > rd) begin
                underflow = 1'b1;
            end else begin
                result = rd - qty;
            end
        end else begin
            result = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/order_book_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : order_book_update_ctrl
//  Description : Read-modify-write engine in front of the price-level memory.
//                Accepts one order event per handshake, reads the level,
//                applies saturating add / clamping subtract, writes back and
//                emits a one-cycle registered update report.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                in_valid/in_ready       - event handshake
//                in_op/in_level/in_qty   - event fields
//                mem_addr/mem_wdata      - memory address / write data
//                mem_write_request       - memory write strobe
//                mem_data_read           - consumes memory read data
//                mem_rdata/mem_out_valid - memory read data / valid
//                upd_valid               - report pulse
//                upd_op/level/qty/err    - report fields
//  Revision    : 1.0 - initial release
// ============================================================================
module order_book_update_ctrl
    import order_book_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_level,
    input  logic [DATA_W-1:0] in_qty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write_request,
    output logic              mem_data_read,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_out_valid,
    output logic              upd_valid,
    output logic [1:0]        upd_op,
    output logic [ADDR_W-1:0] upd_level,
    output logic [DATA_W-1:0] upd_qty,
    output logic [1:0]        upd_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state, state_d;
    op_t                 op_q;
    logic [ADDR_W-1:0]   level_q;
    logic [DATA_W-1:0]   qty_q;
    logic [DATA_W-1:0]   rd_q;
    logic [CNT_W-1:0]    cnt;

    logic                accept;
    logic                capture;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                upd_fire;
    op_t                 upd_op_d;
    logic [ADDR_W-1:0]   upd_level_d;
    logic [DATA_W-1:0]   upd_qty_d;
    err_t                upd_err_d;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_underflow;

    qty_alu #(
        .DATA_W (DATA_W)
    ) u_qty_alu (
        .op        (op_q),
        .rd        (rd_q),
        .qty       (qty_q),
        .result    (alu_result),
        .underflow (alu_underflow)
    );

    // The address always follows the latched level so the memory's idle
    // reads target the level most recently handled.
    assign mem_addr = level_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state;
        in_ready          = (state == IDLE);
        mem_data_read     = 1'b0;
        mem_write_request = 1'b0;
        mem_wdata         = '0;
        accept            = 1'b0;
        capture           = 1'b0;
        cnt_clr           = 1'b0;
        cnt_inc           = 1'b0;
        upd_fire          = 1'b0;
        upd_op_d          = op_q;
        upd_level_d       = level_q;
        upd_qty_d         = '0;
        upd_err_d         = ERR_OK;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (op_t'(in_op) == OP_RSVD) begin
                        // Reserved op is reported immediately; memory untouched.
                        upd_fire    = 1'b1;
                        upd_op_d    = op_t'(in_op);
                        upd_level_d = in_level;
                        upd_err_d   = ERR_ILLEGAL;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_out_valid) begin
                    // Data left over from an idle read is for a stale
                    // address; drop it and retry next cycle.
                    mem_data_read = 1'b1;
                end else begin
                    // Memory launches the read at this edge.
                    state_d = WAIT;
                    cnt_clr = 1'b1;
                end
            end
            WAIT: begin
                if (mem_out_valid) begin
                    mem_data_read = 1'b1;
                    capture       = 1'b1;
                    if (op_q == OP_QUERY) begin
                        state_d   = IDLE;
                        upd_fire  = 1'b1;
                        upd_qty_d = mem_rdata;
                    end else begin
                        state_d = WR;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_d   = IDLE;
                    upd_fire  = 1'b1;
                    upd_err_d = ERR_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WR: begin
                mem_write_request = 1'b1;
                mem_wdata         = alu_result;
                state_d           = IDLE;
                upd_fire          = 1'b1;
                upd_qty_d         = alu_result;
                upd_err_d         = alu_underflow ? ERR_UNDERFLOW : ERR_OK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event latches, read capture, timeout counter and report registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            level_q   <= '0;
            qty_q     <= '0;
            rd_q      <= '0;
            cnt       <= '0;
            upd_valid <= 1'b0;
            upd_op    <= 2'd0;
            upd_level <= '0;
            upd_qty   <= '0;
            upd_err   <= 2'd0;
        end else begin
            if (accept) begin
                op_q    <= op_t'(in_op);
                level_q <= in_level;
                qty_q   <= in_qty;
            end
            if (capture) begin
                rd_q <= mem_rdata;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            upd_valid <= upd_fire;
            if (upd_fire) begin
                upd_op    <= upd_op_d;
                upd_level <= upd_level_d;
                upd_qty   <= upd_qty_d;
                upd_err   <= upd_err_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_order_book_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_order_book_update_ctrl
//  Description : Directed self-checking bench for order_book_update_ctrl with
//                a behavioural price-level memory. mem_hold keeps the memory
//                from launching idle reads so ops can start with no stale data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_order_book_update_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_level;
    logic [DW-1:0] in_qty;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write_request;
    logic          mem_data_read;
    logic [DW-1:0] mem_rdata;
    logic          mem_out_valid;
    logic          upd_valid;
    logic [1:0]    upd_op;
    logic [AW-1:0] upd_level;
    logic [DW-1:0] upd_qty;
    logic [1:0]    upd_err;

    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    logic          mem_hold;
    int            wr_count = 0;
    int            dr_count = 0;
    int            upd_count = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    order_book_update_ctrl #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_op             (in_op),
        .in_level          (in_level),
        .in_qty            (in_qty),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_write_request (mem_write_request),
        .mem_data_read     (mem_data_read),
        .mem_rdata         (mem_rdata),
        .mem_out_valid     (mem_out_valid),
        .upd_valid         (upd_valid),
        .upd_op            (upd_op),
        .upd_level         (upd_level),
        .upd_qty           (upd_qty),
        .upd_err           (upd_err)
    );

    always #5 clk = ~clk;

    // Memory model following the controller's memory contract.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_out_valid <= 1'b0;
            mem_rdata     <= '0;
        end else if (mem_out_valid) begin
            if (mem_data_read) mem_out_valid <= 1'b0;
        end else if (mem_write_request) begin
            mem_arr[mem_addr] = mem_wdata;
            wr_count <= wr_count + 1;
        end else if (!mem_hold) begin
            mem_out_valid <= 1'b1;
            mem_rdata     <= mem_arr[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (mem_data_read) dr_count <= dr_count + 1;
        if (upd_valid)     upd_count <= upd_count + 1;
    end

    // Present an event; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] lvl, input logic [DW-1:0] q);
        in_valid = 1'b1; in_op = op; in_level = lvl; in_qty = q;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 2'd0; in_level = '0; in_qty = '0;
    endtask

    // Edges after the accepting edge until upd_valid is seen (bounded).
    task automatic wait_upd(output int lat);
        lat = 0;
        while (upd_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_level = '0; in_qty = '0;
        mem_hold = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b expected 0", upd_valid); end
        n_checks++; if (mem_write_request !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b expected 0", mem_write_request); end
        n_checks++; if (mem_data_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", mem_data_read); end
        n_checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_bus: got addr %h data %h expected 0 0", mem_addr, mem_wdata); end
        n_checks++; if (upd_qty !== '0 || upd_err !== 2'd0 || upd_op !== 2'd0 || upd_level !== '0) begin
            n_fail++; $display("FAIL reset_upd_fields: got qty %h err %0d op %0d lvl %h expected all 0", upd_qty, upd_err, upd_op, upd_level); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got ready %b upd %b expected 1 0", in_ready, upd_valid); end
    endtask

    task automatic test_add;
        int lat, w0;
        mem_arr[5] = 32'd100;
        w0 = wr_count;
        send(2'd0, 12'd5, 32'd40);
        mem_hold = 1'b0;
        wait_upd(lat);
        mem_hold = 1'b1;
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
        n_checks++; if (upd_qty !== 32'd140 || upd_err !== 2'd0) begin n_fail++; $display("FAIL add_result: got qty %0d err %0d expected 140 0", upd_qty, upd_err); end
        n_checks++; if (upd_op !== 2'd0 || upd_level !== 12'd5) begin n_fail++; $display("FAIL add_echo: got op %0d lvl %0d expected 0 5", upd_op, upd_level); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_with_upd: got %b expected 1", in_ready); end
        n_checks++; if (mem_arr[5] !== 32'd140 || wr_count - w0 !== 1) begin n_fail++; $display("FAIL add_mem: got mem %0d writes %0d expected 140 1", mem_arr[5], wr_count - w0); end
        @(posedge clk); #1;
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL add_pulse_width: got %b expected 0", upd_valid); end
    endtask

    task automatic test_cancel_underflow;
        int lat, w0;
        mem_arr[7] = 32'd30;
        w0 = wr_count;
        send(2'd1, 12'd7, 32'd50);
        mem_hold = 1'b0;
        wait_upd(lat);
        mem_hold = 1'b1;
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL cancel_latency: got %0d expected 3", lat); end
        n_checks++; if (upd_qty !== 32'd0 || upd_err !== 2'd1 || upd_op !== 2'd1) begin
            n_fail++; $display("FAIL cancel_result: got qty %0d err %0d op %0d expected 0 1 1", upd_qty, upd_err, upd_op); end
        n_checks++; if (mem_arr[7] !== 32'd0 || wr_count - w0 !== 1) begin n_fail++; $display("FAIL cancel_mem: got mem %0d writes %0d expected 0 1", mem_arr[7], wr_count - w0); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate_query;
        int lat, w0;
        mem_arr[9] = 32'hFFFF_FFF0;
        send(2'd0, 12'd9, 32'h20);
        mem_hold = 1'b0;
        wait_upd(lat);
        mem_hold = 1'b1;
        n_checks++; if (upd_qty !== 32'hFFFF_FFFF || upd_err !== 2'd0) begin n_fail++; $display("FAIL sat_result: got qty %h err %0d expected ffffffff 0", upd_qty, upd_err); end
        n_checks++; if (mem_arr[9] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_mem: got %h expected ffffffff", mem_arr[9]); end
        @(posedge clk); #1;
        w0 = wr_count;
        send(2'd2, 12'd9, 32'd123);
        mem_hold = 1'b0;
        wait_upd(lat);
        mem_hold = 1'b1;
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL query_latency: got %0d expected 2", lat); end
        n_checks++; if (upd_qty !== 32'hFFFF_FFFF || upd_err !== 2'd0 || upd_op !== 2'd2) begin
            n_fail++; $display("FAIL query_result: got qty %h err %0d op %0d expected ffffffff 0 2", upd_qty, upd_err, upd_op); end
        @(posedge clk); #1;
        n_checks++; if (wr_count !== w0) begin n_fail++; $display("FAIL query_no_write: got %0d writes expected 0", wr_count - w0); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, d0, d1;
        mem_arr[3] = 32'd0;
        d0 = dr_count;
        send(2'd0, 12'd3, 32'd10);
        mem_hold = 1'b0;
        wait_upd(lat1);
        d1 = dr_count;
        n_checks++; if (lat1 !== 3 || upd_qty !== 32'd10) begin n_fail++; $display("FAIL b2b_first: got lat %0d qty %0d expected 3 10", lat1, upd_qty); end
        n_checks++; if (d1 - d0 !== 1) begin n_fail++; $display("FAIL b2b_first_reads: got %0d expected 1", d1 - d0); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        send(2'd0, 12'd3, 32'd5);
        wait_upd(lat2);
        mem_hold = 1'b1;
        n_checks++; if (lat2 !== 4) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 4", lat2); end
        n_checks++; if (dr_count - d1 !== 2) begin n_fail++; $display("FAIL b2b_flush_reads: got %0d expected 2", dr_count - d1); end
        n_checks++; if (upd_qty !== 32'd15 || upd_err !== 2'd0 || mem_arr[3] !== 32'd15) begin
            n_fail++; $display("FAIL b2b_result: got qty %0d err %0d mem %0d expected 15 0 15", upd_qty, upd_err, mem_arr[3]); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal;
        int lat, w0, d0;
        w0 = wr_count; d0 = dr_count;
        send(2'd3, 12'd11, 32'd77);
        wait_upd(lat);
        n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 0", lat); end
        n_checks++; if (upd_err !== 2'd2 || upd_op !== 2'd3 || upd_level !== 12'd11) begin
            n_fail++; $display("FAIL illegal_fields: got err %0d op %0d lvl %0d expected 2 3 11", upd_err, upd_op, upd_level); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b expected 1", in_ready); end
        repeat (2) @(posedge clk); #1;
        n_checks++; if (wr_count !== w0 || dr_count !== d0) begin n_fail++; $display("FAIL illegal_no_mem: got writes %0d reads %0d expected 0 0", wr_count - w0, dr_count - d0); end
    endtask

    task automatic test_timeout;
        int lat, w0;
        mem_arr[20] = 32'd55;
        w0 = wr_count;
        send(2'd0, 12'd20, 32'd1);
        wait_upd(lat);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 17", lat); end
        n_checks++; if (upd_err !== 2'd3 || upd_level !== 12'd20) begin n_fail++; $display("FAIL timeout_fields: got err %0d lvl %0d expected 3 20", upd_err, upd_level); end
        repeat (2) @(posedge clk); #1;
        n_checks++; if (wr_count !== w0 || mem_arr[20] !== 32'd55) begin n_fail++; $display("FAIL timeout_no_write: got writes %0d mem %0d expected 0 55", wr_count - w0, mem_arr[20]); end
    endtask

    task automatic test_reset_in_wr;
        int w0, u0;
        mem_arr[30] = 32'd7;
        w0 = wr_count;
        send(2'd0, 12'd30, 32'd3);
        mem_hold = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (mem_write_request !== 1'b1 || mem_wdata !== 32'd10 || mem_addr !== 12'd30) begin
            n_fail++; $display("FAIL wr_state: got wr %b data %0d addr %0d expected 1 10 30", mem_write_request, mem_wdata, mem_addr); end
        u0 = upd_count;
        rst_n = 1'b0; mem_hold = 1'b1;
        #1;
        n_checks++; if (mem_write_request !== 1'b0 || in_ready !== 1'b1 || upd_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got wr %b ready %b upd %b expected 0 1 0", mem_write_request, in_ready, upd_valid); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (upd_count !== u0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_abort_no_upd: got pulses %0d ready %b expected 0 1", upd_count - u0, in_ready); end
        n_checks++; if (wr_count !== w0 || mem_arr[30] !== 32'd7) begin n_fail++; $display("FAIL reset_abort_mem: got writes %0d mem %0d expected 0 7", wr_count - w0, mem_arr[30]); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = '0;
        test_reset();
        test_add();
        test_cancel_underflow();
        test_saturate_query();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_in_wr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
